c7bbiu_axi_slave_ram: RTL
=========================

Name: c7bbiu_axi_slave_ram

Overview:
- AXI3-style slave/responder with 32-bit data and 4-bit IDs, backed by a word-addressed RAM.
- It is the far end of the BIU master interface: it accepts AR/AW/W and returns R/B.
- It is used as the on-chip RAM target in SoC integration and as the memory model in BIU testbenches.
- Read and write paths are independent; each path holds one outstanding transaction.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- DEPTH, 1024: RAM size in 32-bit words; must be a power of 2.
- IDX_W, 10: word-index width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- ext_biu_ar_ready  out  1  AR ready
- biu_ext_ar_valid  in  1  AR valid
- biu_ext_ar_id  in  4  read ID
- biu_ext_ar_addr  in  32  read byte address
- biu_ext_ar_len  in  8  beats minus 1
- biu_ext_ar_size  in  3  beat size
- biu_ext_ar_burst  in  2  burst type
- biu_ext_ar_lock/cache/prot  in  1/4/3  ignored
- biu_ext_r_ready  in  1  R ready
- ext_biu_r_valid  out  1  R valid
- ext_biu_r_id  out  4  R ID
- ext_biu_r_data  out  32  R data
- ext_biu_r_last  out  1  last beat
- ext_biu_r_resp  out  2  R response
- ext_biu_aw_ready  out  1  AW ready
- biu_ext_aw_valid/id/addr/len/size/burst  in  1/4/32/8/3/2  write address fields
- biu_ext_aw_lock/cache/prot  in  1/4/3  ignored
- ext_biu_w_ready  out  1  W ready
- biu_ext_w_valid/id/data/strb/last  in  1/4/32/4/1  write data; w_id is ignored
- biu_ext_b_ready  in  1  B ready
- ext_biu_b_valid  out  1  B valid
- ext_biu_b_id  out  4  B ID
- ext_biu_b_resp  out  2  B response

Behaviour:
- Reset (resetn=0, asynchronous):
  - Both FSMs go to IDLE.
  - All valid, ready and last outputs are 0; all id, data and resp outputs are 0.
  - RAM contents are not reset.
  - Reset mid-burst abandons the burst with no further R or B.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 2.
  - A beat is in range iff addr >= BASE_ADDR and idx < DEPTH.
  - Address bits [1:0] are ignored.
- Beat error: a beat is an error if it is out of range, or size != 3'b010, or burst == 2'b10 (WRAP) or 2'b11.
- Address advance between beats:
  - INCR (2'b01): +4, with 32-bit wrap.
  - FIXED (2'b00): address held.
  - Error bursts: address still advances as INCR.
- Read FSM, states R_IDLE and R_DATA:
  - ar_ready = 1 only in R_IDLE.
  - AR handshake captures id, addr, len, size and burst, clears the beat counter, and moves to R_DATA.
  - r_valid rises on the clock after the handshake: minimum AR-to-R latency is 1 cycle.
  - r_data is registered: RAM word at the current address, or 32'h0 on an error beat.
  - r_resp is 2'b00, or 2'b10 (SLVERR) on an error beat.
  - r_last = 1 when the beat counter equals the captured len.
  - R fields hold stable while r_valid=1 and r_ready=0.
  - On a non-last beat handshake, the next beat's data is loaded on the same edge and r_valid stays 1 (back-to-back beats).
  - On the last beat handshake: r_valid goes to 0, the FSM returns to R_IDLE, and ar_ready is 1 in the following cycle (no same-cycle AR reuse).
- Write FSM, states W_IDLE, W_DATA and W_RESP:
  - aw_ready = 1 only in W_IDLE.
  - AW handshake captures id, addr, len, size and burst, clears the beat counter and the error flag, and moves to W_DATA.
  - w_ready = 1 only in W_DATA.
  - On a W handshake, RAM byte lane k is written iff strb[k]=1 and the beat is not an error.
  - An error beat sets the sticky error flag; the counter and address then advance.
  - The burst ends on the beat with w_last=1.
  - If the count of received beats != len+1 at w_last, the error flag is set.
  - After w_last, W_RESP drives b_valid=1, b_id = captured id, b_resp = 2'b10 if the error flag is set, else 2'b00.
  - B fields hold until b_ready; the B handshake returns the FSM to W_IDLE.
  - W beats presented before the AW handshake are not accepted (w_ready=0).
- Read/write collision on the same word in the same edge: read data loaded at that edge returns the pre-write value.
- The beat counter is 8 bits. len=255 gives 256 beats; the counter does not overflow before last.

Test Plan:
- Single read: AW/W write 32'hDEADBEEF to BASE+0x10 with strb=4'hF; B returns id=4'h2, resp=00. Then AR id=4'h1, addr BASE+0x10, len=0 -> one cycle later r_valid=1, r_data=32'hDEADBEEF, r_id=1, r_last=1, r_resp=00.
- INCR read burst: len=3 at BASE, words 0..3 preloaded with 0x0,0x1,0x2,0x3; r_ready toggled 1,0,1,1,1 -> data 0,1,2,3 in order, stable during stall, r_last only on beat 4.
- Partial strobe: word = 32'h11223344, then write 32'hAABBCCDD with strb=4'b0101 -> readback 32'h11BB33DD.
- Out-of-range: AR to BASE + 4*DEPTH -> r_resp=10, r_data=0. Write to the same address -> b_resp=10 and RAM unchanged.
- Length mismatch: AW len=1, single W beat with w_last=1 -> B resp=10; aw_ready=1 one cycle after B handshake.
- Async reset asserted mid read burst -> r_valid=0 immediately, ar_ready=0 during reset, 1 after release; the next AR completes normally.

Source files
------------

// File: rtl/c7bbiu_axi_slave_ram_if.sv
// AXI3-style bus between a BIU master and the on-chip RAM responder.
// Signal names keep the BIU's driver prefix: biu_ext_* from the master, ext_biu_* from the slave.
interface c7bbiu_axi_slave_ram_if;
  logic        ext_biu_ar_ready;
  logic        biu_ext_ar_valid;
  logic [3:0]  biu_ext_ar_id;
  logic [31:0] biu_ext_ar_addr;
  logic [7:0]  biu_ext_ar_len;
  logic [2:0]  biu_ext_ar_size;
  logic [1:0]  biu_ext_ar_burst;
  logic        biu_ext_ar_lock;
  logic [3:0]  biu_ext_ar_cache;
  logic [2:0]  biu_ext_ar_prot;

  logic        biu_ext_r_ready;
  logic        ext_biu_r_valid;
  logic [3:0]  ext_biu_r_id;
  logic [31:0] ext_biu_r_data;
  logic        ext_biu_r_last;
  logic [1:0]  ext_biu_r_resp;

  logic        ext_biu_aw_ready;
  logic        biu_ext_aw_valid;
  logic [3:0]  biu_ext_aw_id;
  logic [31:0] biu_ext_aw_addr;
  logic [7:0]  biu_ext_aw_len;
  logic [2:0]  biu_ext_aw_size;
  logic [1:0]  biu_ext_aw_burst;
  logic        biu_ext_aw_lock;
  logic [3:0]  biu_ext_aw_cache;
  logic [2:0]  biu_ext_aw_prot;

  logic        ext_biu_w_ready;
  logic        biu_ext_w_valid;
  logic [3:0]  biu_ext_w_id;
  logic [31:0] biu_ext_w_data;
  logic [3:0]  biu_ext_w_strb;
  logic        biu_ext_w_last;

  logic        biu_ext_b_ready;
  logic        ext_biu_b_valid;
  logic [3:0]  ext_biu_b_id;
  logic [1:0]  ext_biu_b_resp;

  modport master (
    input  ext_biu_ar_ready, ext_biu_r_valid, ext_biu_r_id, ext_biu_r_data, ext_biu_r_last,
           ext_biu_r_resp, ext_biu_aw_ready, ext_biu_w_ready, ext_biu_b_valid, ext_biu_b_id,
           ext_biu_b_resp,
    output biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, biu_ext_ar_len, biu_ext_ar_size,
           biu_ext_ar_burst, biu_ext_ar_lock, biu_ext_ar_cache, biu_ext_ar_prot, biu_ext_r_ready,
           biu_ext_aw_valid, biu_ext_aw_id, biu_ext_aw_addr, biu_ext_aw_len, biu_ext_aw_size,
           biu_ext_aw_burst, biu_ext_aw_lock, biu_ext_aw_cache, biu_ext_aw_prot, biu_ext_w_valid,
           biu_ext_w_id, biu_ext_w_data, biu_ext_w_strb, biu_ext_w_last, biu_ext_b_ready
  );

  modport slave (
    output ext_biu_ar_ready, ext_biu_r_valid, ext_biu_r_id, ext_biu_r_data, ext_biu_r_last,
           ext_biu_r_resp, ext_biu_aw_ready, ext_biu_w_ready, ext_biu_b_valid, ext_biu_b_id,
           ext_biu_b_resp,
    input  biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr, biu_ext_ar_len, biu_ext_ar_size,
           biu_ext_ar_burst, biu_ext_ar_lock, biu_ext_ar_cache, biu_ext_ar_prot, biu_ext_r_ready,
           biu_ext_aw_valid, biu_ext_aw_id, biu_ext_aw_addr, biu_ext_aw_len, biu_ext_aw_size,
           biu_ext_aw_burst, biu_ext_aw_lock, biu_ext_aw_cache, biu_ext_aw_prot, biu_ext_w_valid,
           biu_ext_w_id, biu_ext_w_data, biu_ext_w_strb, biu_ext_w_last, biu_ext_b_ready
  );
endinterface

// File: rtl/c7bbiu_axi_slave_ram.sv
// AXI3-style RAM responder: independent read and write paths, one outstanding burst each.
// Word-addressed 32-bit RAM at BASE_ADDR; bad address/size/burst beats answer SLVERR.
module c7bbiu_axi_slave_ram #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned IDX_W     = 10
) (
  input logic                   clk,
  input logic                   resetn,
  c7bbiu_axi_slave_ram_if.slave bus
);
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  logic [31:0] mem [DEPTH];

  // A borrow from the subtraction lands above 4*DEPTH, so one compare covers both bounds.
  function automatic logic in_range(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return off < (33'(DEPTH) << 2);
  endfunction

  function automatic logic beat_err(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [1:0] burst);
    return !in_range(addr) || (size != 3'b010) || burst[1];
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  r_state_e    r_state_q, r_state_d;
  logic        ar_ready, r_valid, ar_hs, r_hs, r_load;
  logic [31:0] r_addr_q, rd_addr, r_data_q;
  logic [7:0]  r_len_q, rd_len, r_cnt_q, rd_cnt;
  logic [2:0]  r_size_q, rd_size;
  logic [1:0]  r_burst_q, rd_burst, r_resp_q;
  logic [3:0]  r_id_q;
  logic        r_last_q, rd_err;

  w_state_e    w_state_q, w_state_d;
  logic        aw_ready, w_ready, b_valid, aw_hs, w_hs;
  logic [31:0] w_addr_q;
  logic [7:0]  w_len_q, w_cnt_q;
  logic [2:0]  w_size_q;
  logic [1:0]  w_burst_q, b_resp_q;
  logic [3:0]  w_id_q, b_id_q;
  logic        w_err_q, w_beat_err, w_len_bad;

  assign ar_hs  = ar_ready && bus.biu_ext_ar_valid;
  assign r_hs   = r_valid && bus.biu_ext_r_ready;
  assign r_load = ar_hs || (r_hs && !r_last_q);
  assign aw_hs  = aw_ready && bus.biu_ext_aw_valid;
  assign w_hs   = w_ready && bus.biu_ext_w_valid;

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
    end
  end

  // Ready is gated by resetn so nothing is accepted while reset is held.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    r_state_d = r_state_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = resetn;
        if (ar_hs) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (bus.biu_ext_r_ready && r_last_q) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = resetn;
        if (aw_hs) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (bus.biu_ext_w_valid && bus.biu_ext_w_last) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (bus.biu_ext_b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Beat to present next: the fresh AR on a handshake, else the advance of the current beat.
  always_comb begin
    rd_addr  = next_addr(r_addr_q, r_burst_q);
    rd_len   = r_len_q;
    rd_size  = r_size_q;
    rd_burst = r_burst_q;
    rd_cnt   = r_cnt_q + 8'd1;
    if (ar_hs) begin
      rd_addr  = bus.biu_ext_ar_addr;
      rd_len   = bus.biu_ext_ar_len;
      rd_size  = bus.biu_ext_ar_size;
      rd_burst = bus.biu_ext_ar_burst;
      rd_cnt   = 8'd0;
    end
    rd_err = beat_err(rd_addr, rd_size, rd_burst);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_id_q    <= '0;
      r_data_q  <= '0;
      r_last_q  <= 1'b0;
      r_resp_q  <= '0;
    end else if (r_load) begin
      if (ar_hs) r_id_q <= bus.biu_ext_ar_id;
      r_addr_q  <= rd_addr;
      r_len_q   <= rd_len;
      r_size_q  <= rd_size;
      r_burst_q <= rd_burst;
      r_cnt_q   <= rd_cnt;
      r_data_q  <= rd_err ? 32'h0 : mem[word_idx(rd_addr)];
      r_resp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      r_last_q  <= (rd_cnt == rd_len);
    end
  end

  assign w_beat_err = beat_err(w_addr_q, w_size_q, w_burst_q);
  assign w_len_bad  = (w_cnt_q != w_len_q);

  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; contents survive resetn.
    if (w_hs && !w_beat_err) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.biu_ext_w_strb[k]) mem[word_idx(w_addr_q)][8*k +: 8] <= bus.biu_ext_w_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      b_id_q    <= '0;
      b_resp_q  <= '0;
    end else if (aw_hs) begin
      w_id_q    <= bus.biu_ext_aw_id;
      w_addr_q  <= bus.biu_ext_aw_addr;
      w_len_q   <= bus.biu_ext_aw_len;
      w_size_q  <= bus.biu_ext_aw_size;
      w_burst_q <= bus.biu_ext_aw_burst;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else if (w_hs) begin
      w_addr_q <= next_addr(w_addr_q, w_burst_q);
      w_cnt_q  <= w_cnt_q + 8'd1;
      if (w_beat_err || (bus.biu_ext_w_last && w_len_bad)) w_err_q <= 1'b1;
      if (bus.biu_ext_w_last) begin
        b_id_q   <= w_id_q;
        b_resp_q <= (w_err_q || w_beat_err || w_len_bad) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign bus.ext_biu_ar_ready = ar_ready;
  assign bus.ext_biu_r_valid  = r_valid;
  assign bus.ext_biu_r_id     = r_id_q;
  assign bus.ext_biu_r_data   = r_data_q;
  assign bus.ext_biu_r_last   = r_last_q;
  assign bus.ext_biu_r_resp   = r_resp_q;
  assign bus.ext_biu_aw_ready = aw_ready;
  assign bus.ext_biu_w_ready  = w_ready;
  assign bus.ext_biu_b_valid  = b_valid;
  assign bus.ext_biu_b_id     = b_id_q;
  assign bus.ext_biu_b_resp   = b_resp_q;

  logic unused_ok;
  assign unused_ok = ^{bus.biu_ext_ar_lock, bus.biu_ext_ar_cache, bus.biu_ext_ar_prot,
                       bus.biu_ext_aw_lock, bus.biu_ext_aw_cache, bus.biu_ext_aw_prot,
                       bus.biu_ext_w_id};
endmodule
